// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer that sweeps AB=00..11 through a 2-input gate and checks its output against EXPECT.
// Optional GATE_SWEEP_LOG_EN adds tt_obs, the observed truth table of the final pass.
module gate_sweep_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b0110,
  parameter int         NUM_PASSES    = 1,
  parameter int         ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_c,
  output logic [1:0]       idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_SWEEP_LOG_EN
  ,
  output logic [3:0]       tt_obs
`endif
);

  localparam int CNT_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = (NUM_PASSES < 2) ? 1 : $clog2(NUM_PASSES);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   settle_cnt;
  logic [PASS_W-1:0]  pass_cnt;
  logic               miss;
  logic               last_pass;
  logic [ERR_W-1:0]   err_next;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign miss      = (gate_c != EXPECT[idx]);
  assign last_pass = (pass_cnt == PASS_W'(NUM_PASSES - 1));
  assign err_next  = miss ? sat_inc(err_count) : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      idx        <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
`ifdef GATE_SWEEP_LOG_EN
      tt_obs     <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          if (start) begin
            idx       <= 2'd0;
            err_count <= '0;
            pass      <= 1'b0;
            pass_cnt  <= '0;
            busy      <= 1'b1;
            state     <= DRIVE;
`ifdef GATE_SWEEP_LOG_EN
            tt_obs    <= 4'd0;
`endif
          end
        end
        DRIVE: begin
          // Gate inputs were already updated on entry, so the vector is stable from this cycle on.
          settle_cnt <= CNT_W'(SETTLE_CYCLES);
          state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (settle_cnt <= CNT_W'(1)) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
`ifdef GATE_SWEEP_LOG_EN
          tt_obs[idx] <= gate_c;
`endif
          if (idx == 2'd3 && last_pass) begin
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_next == '0);
            state  <= FIN;
          end else begin
            if (idx == 2'd3) begin
              pass_cnt <= pass_cnt + 1'b1;
            end
            idx              <= idx + 2'd1;
            {gate_a, gate_b} <= idx + 2'd1;
            state            <= DRIVE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl: three configurations driven by behavioural GUT tables.
module tb_gate_sweep_ctrl;

  localparam logic [3:0] EXP_TT = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [3];
  logic       ga    [3];
  logic       gb    [3];
  logic       gc    [3];
  logic [1:0] idx   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [2:0] err   [3];
  logic [3:0] gut   [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: two passes; 2: no settle cycles.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_sweep_ctrl #(
      .SETTLE_CYCLES((g == 2) ? 0 : 2),
      .EXPECT       (EXP_TT),
      .NUM_PASSES   ((g == 1) ? 2 : 1),
      .ERR_W        (3)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .gate_a   (ga[g]),
      .gate_b   (gb[g]),
      .gate_c   (gc[g]),
      .idx      (idx[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .err_count(err[g])
    );
    assign gc[g] = gut[g][{ga[g], gb[g]}];
  end

  function automatic int settle_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  function automatic int passes_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // mode 0: plain sweep, 1: stray start pulse mid-sweep, 2: start held high, 3: reset in SETTLE of idx 2
  task automatic run_sweep(input int d, input logic [3:0] tt, input int mode);
    int s, np, vlen, len, mism, exp_err, bad, done_t, cnt, exp_v;
    bit exp_busy;
    s       = settle_of(d);
    np      = passes_of(d);
    vlen    = s + 2;
    len     = 4 * np * vlen;
    mism    = np * $countones(tt ^ EXP_TT);
    exp_err = (mism > 7) ? 7 : mism;
    bad     = 0;
    done_t  = -1;
    gut[d]  = tt;
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    if (mode != 2) start[d] = 1'b0;
    for (int t = 0; t <= len; t++) begin
      exp_busy = (t < len);
      exp_v    = exp_busy ? (t / vlen) % 4 : 0;
      if (busy[d] !== exp_busy || {ga[d], gb[d]} !== 2'(exp_v) || done[d] !== (t == len)) bad++;
      if (exp_busy && idx[d] !== 2'(exp_v)) bad++;
      if (done[d] === 1'b1 && done_t < 0) done_t = t;
      if (mode == 1) start[d] = (t == len / 2);
      if (mode == 3 && t == 2 * vlen + 1) begin
        chk("trace_pre_abort", bad, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy[d], 0);
        chk("abort_gates", {ga[d], gb[d]}, 0);
        chk("abort_err", err[d], 0);
        chk("abort_pass", pass[d], 0);
        chk("abort_idx", idx[d], 0);
        cnt = 0;
        for (int k = 0; k < len + 4; k++) begin
          if (done[d] === 1'b1 || busy[d] === 1'b1) cnt++;
          @(posedge clk); #1;
        end
        chk("abort_no_done", cnt, 0);
        return;
      end
      if (t < len) begin
        @(posedge clk); #1;
      end
    end
    start[d] = (mode == 2);
    chk("trace", bad, 0);
    chk("done_cycle", done_t + 1, len + 1);
    chk("err_count", err[d], exp_err);
    chk("pass", pass[d], (mism == 0));
    chk("idx_final", idx[d], 3);
    @(posedge clk); #1;
    chk("done_one_cycle", done[d], 0);
    chk("busy_idle", busy[d], 0);
    if (mode == 2) begin
      @(posedge clk); #1;
      chk("retrigger", busy[d], 1);
      start[d] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("retrig_reset", busy[d], 0);
    end else begin
      chk("err_hold", err[d], exp_err);
      chk("pass_hold", pass[d], (mism == 0));
      cnt = 0;
      for (int k = 0; k < len; k++) begin
        if (busy[d] === 1'b1 || done[d] === 1'b1) cnt++;
        @(posedge clk); #1;
      end
      chk("no_extra_sweep", cnt, 0);
    end
  endtask

  initial begin
    int d, m;
    logic [3:0] tt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      gut[i]   = EXP_TT;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_gates", {ga[i], gb[i]}, 0);
      chk("rst_flags", {busy[i], done[i], pass[i]}, 0);
      chk("rst_idx_err", {idx[i], err[i]}, 0);
    end
    rst = 1'b0;

    run_sweep(0, 4'b0110, 0);
    run_sweep(0, 4'b0000, 0);
    run_sweep(0, 4'b1111, 0);
    run_sweep(1, 4'b1001, 0);
    run_sweep(2, 4'b0110, 1);
    run_sweep(0, 4'b0000, 3);
    run_sweep(0, 4'b0110, 2);
    run_sweep(1, 4'b0110, 0);

    for (int i = 0; i < 16; i++) begin
      d  = $urandom_range(0, 2);
      tt = 4'($urandom_range(0, 15));
      m  = $urandom_range(0, 3);
      if (m == 3 && settle_of(d) == 0) m = 0;
      run_sweep(d, tt, m);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
